ysyx_22040759_bpu: RTL
======================

# ysyx_22040759_bpu

Parametrised branch prediction and resolution unit for the ysyx_22040759 core. It supersedes the static execute-stage branch unit with three additions: all six RISC-V conditional compares plus JAL/JALR, a BHT_DEPTH-entry direction/target table read at fetch, and a registered mispredict-redirect output. Fetch reads a prediction combinationally. Execute resolves the branch, trains the table, and drives the front-end redirect one cycle later.

## Interface
- XLEN, 64: datapath and PC width.
- BHT_DEPTH, 64: table entries; power of two, at least 4; IDX = log2(BHT_DEPTH).
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_pc  in  XLEN  fetch PC to look up.
- if_pred_taken  out  1  predicted taken; combinational.
- if_pred_target  out  XLEN  predicted target; combinational; valid only when if_pred_taken=1.
- ex_valid  in  1  the execute-stage instruction is valid.
- ex_sel  in  4  operation: NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR.
- ex_src1, ex_src2  in  XLEN  operands.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_pc  in  XLEN  PC of the execute-stage instruction.
- ex_pred_taken, ex_pred_target  in  1, XLEN  prediction carried down the pipe with the instruction.
- redirect_valid  out  1  registered mispredict pulse.
- redirect_pc  out  XLEN  registered correct next PC.
- br_cnt, mispred_cnt  out  CNT_W  resolved control-flow instructions and mispredicts.

## Operation
- Each entry holds valid, tag, target and a 2-bit counter ctr.
  - Index = pc[IDX+1:2].
  - Tag = pc[XLEN-1:IDX+2].
- Lookup: hit = valid && tag match. if_pred_taken = hit && ctr[1]. if_pred_target = entry target.
- Resolution applies only when ex_valid=1 and ex_sel!=NONE.
- Condition codes:
  - BEQ: eq.
  - BNE: !eq.
  - BLT: signed lt.
  - BGE: !signed lt.
  - BLTU: unsigned lt.
  - BGEU: !unsigned lt.
  - JAL and JALR: always taken.
- Target:
  - JALR: (src1+imm) & ~1.
  - All others: ex_pc+imm.
- All additions are modulo 2^XLEN.
- next_pc = taken ? target : ex_pc+4.
- mispredict = (taken != ex_pred_taken) || (taken && target != ex_pred_target).
- Table update at the clock edge:
  - Hit, conditional branch: ctr saturating increment if taken, decrement if not taken. Target is rewritten when taken.
  - Hit, JAL or JALR: ctr set to 11; target rewritten.
  - Miss and taken: allocate (overwrite) the entry with valid=1, the new tag and target. ctr = 10 for a conditional branch, 11 for JAL/JALR.
  - Miss and not taken: no table write.
- Counters:
  - br_cnt increments on every resolution.
  - mispred_cnt increments on every mispredict.
  - Both saturate at all-ones.

## Timing
- Lookup is zero latency. If lookup and update hit the same index in one cycle, lookup returns the pre-update contents.
- Resolution to redirect is one cycle.
  - redirect_valid is high for exactly one cycle, the cycle after a mispredicting resolution.
  - redirect_pc holds next_pc from that resolution.
- redirect_valid is 0 after any non-mispredicting or invalid cycle. redirect_pc holds its last value.
- Back-to-back mispredicts produce consecutive pulses, each carrying its own PC.
- Reset values:
  - redirect_valid=0, redirect_pc=0, br_cnt=0, mispred_cnt=0.
  - All entries valid=0, ctr=01.
- Asserting rst_n low mid-operation clears everything immediately. A pending redirect is dropped.

## Configuration
- YSYX_22040759_BPU_BHT_EN defined: table instantiated and behaviour as above.
- Undefined:
  - No table storage exists.
  - if_pred_taken=0 and if_pred_target=0 constantly (static not-taken).
  - Resolution, redirect and counters are unchanged.

## Structure
- Shared defines/package holds:
  - the ex_sel encodings: NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6, JAL=7, JALR=8;
  - the ctr reset and allocation constants.
- Sub-module ysyx_22040759_bpu_resolve (combinational) computes taken, target, next_pc and mispredict from the ex_* inputs.
- The top level holds the table, the redirect register and the counters.

## Test plan
- Reset then lookup of if_pc=0x8000_0000 -> if_pred_taken=0; redirect_valid=0; both counters 0.
- BEQ, src1=src2=5, imm=0x10, ex_pc=0x8000_0000, pred not-taken -> next cycle redirect_valid=1, redirect_pc=0x8000_0010; lookup of 0x8000_0000 then predicts taken, target 0x8000_0010.
- BLTU, src1=1, src2=0xFFFF_FFFF_FFFF_FFFF -> taken. BLT with the same operands -> not taken, redirect_pc=ex_pc+4.
- JALR, src1=0x8000_0101, imm=2, pred taken with target 0x8000_0102 -> redirect_valid=0. The same with pred target 0x8000_0100 -> redirect to 0x8000_0102.
- Counter training: four not-taken resolutions after one taken allocation -> ctr saturates at 00 and prediction is not-taken; mispred_cnt=2.
- Assert rst_n low during a redirect pulse -> redirect_valid=0 immediately; table cleared.

Source files
------------

// File: rtl/ysyx_22040759_bpu_pkg.sv
// Shared encodings for the ysyx_22040759 branch unit: ex_sel operation codes
// and the 2-bit direction counter constants.
package ysyx_22040759_bpu_pkg;

   localparam int SEL_W = 4;

   typedef enum logic [SEL_W-1:0] {
      SEL_NONE = 4'd0,
      SEL_BEQ  = 4'd1,
      SEL_BNE  = 4'd2,
      SEL_BLT  = 4'd3,
      SEL_BGE  = 4'd4,
      SEL_BLTU = 4'd5,
      SEL_BGEU = 4'd6,
      SEL_JAL  = 4'd7,
      SEL_JALR = 4'd8
   } bpu_sel_e;

   localparam logic [1:0] CTR_RST      = 2'b01;
   localparam logic [1:0] CTR_ALLOC_BR = 2'b10;
   localparam logic [1:0] CTR_JUMP     = 2'b11;

endpackage

// File: rtl/ysyx_22040759_bpu_if.sv
// Fetch-lookup, execute-resolve and redirect signals of the branch unit.
// master = core side, slave = branch unit.
interface ysyx_22040759_bpu_if
   import ysyx_22040759_bpu_pkg::*;
#(
   parameter int XLEN = 64
);
   logic [XLEN-1:0]  if_pc;
   logic             if_pred_taken;
   logic [XLEN-1:0]  if_pred_target;
   logic             ex_valid;
   logic [SEL_W-1:0] ex_sel;
   logic [XLEN-1:0]  ex_src1;
   logic [XLEN-1:0]  ex_src2;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_pc;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;

   modport master (
      output if_pc, ex_valid, ex_sel, ex_src1, ex_src2, ex_imm, ex_pc,
             ex_pred_taken, ex_pred_target,
      input  if_pred_taken, if_pred_target, redirect_valid, redirect_pc
   );

   modport slave (
      input  if_pc, ex_valid, ex_sel, ex_src1, ex_src2, ex_imm, ex_pc,
             ex_pred_taken, ex_pred_target,
      output if_pred_taken, if_pred_target, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ysyx_22040759_bpu_resolve.sv
// Combinational branch resolution: direction, target, next PC and mispredict
// for the instruction in execute.
module ysyx_22040759_bpu_resolve
   import ysyx_22040759_bpu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic             ex_valid_i,
   input  logic [SEL_W-1:0] ex_sel_i,
   input  logic [XLEN-1:0]  ex_src1_i,
   input  logic [XLEN-1:0]  ex_src2_i,
   input  logic [XLEN-1:0]  ex_imm_i,
   input  logic [XLEN-1:0]  ex_pc_i,
   input  logic             ex_pred_taken_i,
   input  logic [XLEN-1:0]  ex_pred_target_i,
   output logic             active_o,
   output logic             is_jump_o,
   output logic             taken_o,
   output logic [XLEN-1:0]  target_o,
   output logic [XLEN-1:0]  next_pc_o,
   output logic             mispredict_o
);
   logic            eq;
   logic            slt;
   logic            ult;
   logic [XLEN-1:0] jalr_sum;

   assign eq       = (ex_src1_i == ex_src2_i);
   assign slt      = ($signed(ex_src1_i) < $signed(ex_src2_i));
   assign ult      = (ex_src1_i < ex_src2_i);
   assign jalr_sum = ex_src1_i + ex_imm_i;

   always_comb begin
      active_o  = 1'b1;
      is_jump_o = 1'b0;
      taken_o   = 1'b0;
      target_o  = ex_pc_i + ex_imm_i;
      case (ex_sel_i)
         SEL_BEQ:  taken_o = eq;
         SEL_BNE:  taken_o = !eq;
         SEL_BLT:  taken_o = slt;
         SEL_BGE:  taken_o = !slt;
         SEL_BLTU: taken_o = ult;
         SEL_BGEU: taken_o = !ult;
         SEL_JAL: begin
            is_jump_o = 1'b1;
            taken_o   = 1'b1;
         end
         SEL_JALR: begin
            is_jump_o = 1'b1;
            taken_o   = 1'b1;
            target_o  = {jalr_sum[XLEN-1:1], 1'b0};
         end
         // NONE and the unused encodings resolve nothing
         default:  active_o = 1'b0;
      endcase
      active_o = active_o && ex_valid_i;
   end

   assign next_pc_o    = taken_o ? target_o : ex_pc_i + XLEN'(4);
   assign mispredict_o = (taken_o != ex_pred_taken_i) ||
                         (taken_o && (target_o != ex_pred_target_i));

endmodule

// File: rtl/ysyx_22040759_bpu.sv
// Branch prediction/resolution unit: optional direction/target table
// (YSYX_22040759_BPU_BHT_EN), registered redirect and saturating counters.
module ysyx_22040759_bpu
   import ysyx_22040759_bpu_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   ysyx_22040759_bpu_if.slave  bus,
   output logic [CNT_W-1:0]    br_cnt,
   output logic [CNT_W-1:0]    mispred_cnt
);
   logic            res_active;
   logic            res_jump;
   logic            res_taken;
   logic            res_mispredict;
   logic [XLEN-1:0] res_target;
   logic [XLEN-1:0] res_next_pc;

   ysyx_22040759_bpu_resolve #(.XLEN(XLEN)) u_resolve (
      .ex_valid_i       (bus.ex_valid),
      .ex_sel_i         (bus.ex_sel),
      .ex_src1_i        (bus.ex_src1),
      .ex_src2_i        (bus.ex_src2),
      .ex_imm_i         (bus.ex_imm),
      .ex_pc_i          (bus.ex_pc),
      .ex_pred_taken_i  (bus.ex_pred_taken),
      .ex_pred_target_i (bus.ex_pred_target),
      .active_o         (res_active),
      .is_jump_o        (res_jump),
      .taken_o          (res_taken),
      .target_o         (res_target),
      .next_pc_o        (res_next_pc),
      .mispredict_o     (res_mispredict)
   );

   logic             flush;
   logic             redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   assign flush = res_active && res_mispredict;

   always_comb begin
      redirect_valid_d = flush;
      redirect_pc_d    = flush ? res_next_pc : redirect_pc_q;
      br_cnt_d         = (res_active && (br_cnt_q != '1)) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
      mispred_cnt_d    = (flush && (mispred_cnt_q != '1)) ? mispred_cnt_q + CNT_W'(1)
                                                          : mispred_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         br_cnt_q         <= '0;
         mispred_cnt_q    <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         br_cnt_q         <= br_cnt_d;
         mispred_cnt_q    <= mispred_cnt_d;
      end
   end

   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign br_cnt             = br_cnt_q;
   assign mispred_cnt        = mispred_cnt_q;

`ifdef YSYX_22040759_BPU_BHT_EN
   localparam int IDX   = $clog2(BHT_DEPTH);
   localparam int TAG_W = XLEN - IDX - 2;

   logic [BHT_DEPTH-1:0] ent_valid;
   logic [TAG_W-1:0]     ent_tag [BHT_DEPTH];
   logic [XLEN-1:0]      ent_tgt [BHT_DEPTH];
   logic [1:0]           ent_ctr [BHT_DEPTH];

   logic [IDX-1:0]   lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, up_hit, up_write;
   logic [1:0]       up_ctr, ctr_d;

   assign lk_idx = bus.if_pc[IDX+1:2];
   assign lk_tag = bus.if_pc[XLEN-1:IDX+2];
   assign lk_hit = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);

   // Lookup reads the registered entries, so a same-cycle update is not visible yet
   assign bus.if_pred_taken  = lk_hit && ent_ctr[lk_idx][1];
   assign bus.if_pred_target = ent_tgt[lk_idx];

   assign up_idx = bus.ex_pc[IDX+1:2];
   assign up_tag = bus.ex_pc[XLEN-1:IDX+2];
   assign up_hit = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
   assign up_ctr = ent_ctr[up_idx];

   always_comb begin
      up_write = res_active && (up_hit || res_taken);
      ctr_d    = res_jump ? CTR_JUMP : CTR_ALLOC_BR;
      if (up_hit && !res_jump) begin
         if (res_taken) ctr_d = (up_ctr == 2'b11) ? up_ctr : up_ctr + 2'd1;
         else           ctr_d = (up_ctr == 2'b00) ? up_ctr : up_ctr - 2'd1;
      end
   end

   for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
      logic             valid_q;
      logic [TAG_W-1:0] tag_q;
      logic [XLEN-1:0]  tgt_q;
      logic [1:0]       ctr_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= CTR_RST;
         end else if (up_write && (up_idx == IDX'(gi))) begin
            valid_q <= 1'b1;
            tag_q   <= up_tag;
            ctr_q   <= ctr_d;
            if (res_taken) tgt_q <= res_target;
         end
      end

      assign ent_valid[gi] = valid_q;
      assign ent_tag[gi]   = tag_q;
      assign ent_tgt[gi]   = tgt_q;
      assign ent_ctr[gi]   = ctr_q;
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^bus.if_pc[1:0];
`else
   // Static not-taken front end; resolution still reports every mispredict
   assign bus.if_pred_taken  = 1'b0;
   assign bus.if_pred_target = '0;

   localparam int unused_depth = BHT_DEPTH;
   logic unused_bht;
   assign unused_bht = ^{bus.if_pc, res_taken, res_target, res_jump};
`endif

endmodule
